// File: rtl/pulseack_evt_arb_pkg.sv
// Shared types and constants for the pulse-ack event arbiter.
// The optional ack timeout is enabled by defining PULSEACK_EVT_ARB_TIMEOUT_EN.
package pulseack_evt_arb_pkg;

  // Largest requester count the arbiter is sized for
  localparam int NUM_REQ_MAX = 16;

  // Width of the WAIT_ACK timeout counter (covers ACK_TMO up to 65535)
  localparam int TMO_CNT_W = 16;

  // Arbiter control states
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ISSUE    = 2'd1,
    ST_WAIT_ACK = 2'd2
  } arb_state_t;

  // Next round-robin position after idx, wrapping n-1 -> 0
  function automatic int rr_next(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/pulseack_rr_arb.sv
// Combinational round-robin picker: first set bit of i_pend at or after
// i_ptr, searching upward and wrapping NUM_REQ-1 -> 0.
module pulseack_rr_arb #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_pend,
  input  logic [IDX_W-1:0]   i_ptr,
  output logic               o_vld,
  output logic [IDX_W-1:0]   o_idx
);

  int w_cand;

  // Walk the pending vector starting at the pointer; the first hit wins
  always_comb begin
    o_vld  = 1'b0;
    o_idx  = '0;
    w_cand = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_cand = (int'(i_ptr) + k) % NUM_REQ;
      if (!o_vld && i_pend[w_cand]) begin
        o_vld = 1'b1;
        o_idx = IDX_W'(w_cand);
      end
    end
  end

endmodule

// File: rtl/pulseack_evt_arb.sv
// Round-robin arbiter funnelling per-requester event pulses into one shared
// pulse-ack synchronizer. Requests are latched into a pending vector, one
// winner at a time is issued as a single-cycle event_s, and its completion is
// reported on done_s once the synchronizer acknowledges.
// Optional feature: define PULSEACK_EVT_ARB_TIMEOUT_EN to abandon a transfer
// with an err_s pulse after ACK_TMO cycles in WAIT_ACK without ack_s.
module pulseack_evt_arb
  import pulseack_evt_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ACK_TMO = 255
) (
  input  logic                       clk_s,
  input  logic                       rst_s,
  input  logic [NUM_REQ-1:0]         req_s,
  output logic [NUM_REQ-1:0]         done_s,
  output logic                       err_s,
  output logic                       ovf_s,
  output logic [$clog2(NUM_REQ)-1:0] gnt_id_s,
  output logic                       active_s,
  output logic                       event_s,
  input  logic                       busy_s,
  input  logic                       ack_s
);

  localparam int IDX_W = $clog2(NUM_REQ);

  arb_state_t         r_state;
  logic [NUM_REQ-1:0] r_pend;
  logic [IDX_W-1:0]   r_ptr;
  logic [IDX_W-1:0]   r_gnt;
  logic [NUM_REQ-1:0] r_done;
  logic               r_event;
  logic               r_ovf;
  logic               r_active;

  logic               w_win_vld;
  logic [IDX_W-1:0]   w_win_idx;
  logic               w_grant;
  logic [NUM_REQ-1:0] w_grant_clr;
  logic [NUM_REQ-1:0] w_pend_nxt;
  logic               w_ovf_nxt;
  logic [NUM_REQ-1:0] w_gnt_onehot;
  logic [IDX_W-1:0]   w_ptr_adv;

`ifdef PULSEACK_EVT_ARB_TIMEOUT_EN
  localparam logic [TMO_CNT_W-1:0] TMO_LAST = TMO_CNT_W'(ACK_TMO - 1);
  logic [TMO_CNT_W-1:0] r_cnt;
  logic                 r_err;
`endif

  pulseack_rr_arb #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr (
    .i_pend (r_pend),
    .i_ptr  (r_ptr),
    .o_vld  (w_win_vld),
    .o_idx  (w_win_idx)
  );

  // A grant happens only from IDLE with something pending and the synchronizer free
  assign w_grant      = (r_state == ST_IDLE) && w_win_vld && !busy_s;
  assign w_gnt_onehot = NUM_REQ'(1) << r_gnt;
  assign w_ptr_adv    = IDX_W'(rr_next(int'(r_gnt), NUM_REQ));

  // Pending-vector update: clear the bit being granted, then OR in new pulses.
  // A pulse on a bit being cleared this cycle counts as a new event, not a coalesce.
  always_comb begin
    w_grant_clr = '0;
    if (w_grant) begin
      w_grant_clr = NUM_REQ'(1) << w_win_idx;
    end
    w_pend_nxt = (r_pend & ~w_grant_clr) | req_s;
    w_ovf_nxt  = |(req_s & r_pend & ~w_grant_clr);
  end

  // Arbiter FSM with pending latch and registered outputs
  always_ff @(posedge clk_s) begin
    if (rst_s) begin
      r_state  <= ST_IDLE;
      r_pend   <= '0;
      r_ptr    <= '0;
      r_gnt    <= '0;
      r_done   <= '0;
      r_event  <= 1'b0;
      r_ovf    <= 1'b0;
      r_active <= 1'b0;
`ifdef PULSEACK_EVT_ARB_TIMEOUT_EN
      r_cnt    <= '0;
      r_err    <= 1'b0;
`endif
    end else begin
      r_pend  <= w_pend_nxt;
      r_ovf   <= w_ovf_nxt;
      r_event <= 1'b0;
      r_done  <= '0;
`ifdef PULSEACK_EVT_ARB_TIMEOUT_EN
      r_err   <= 1'b0;
`endif
      case (r_state)
        ST_IDLE: begin
          if (w_grant) begin
            r_gnt    <= w_win_idx;
            r_active <= 1'b1;
            r_state  <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          r_event <= 1'b1;
`ifdef PULSEACK_EVT_ARB_TIMEOUT_EN
          r_cnt   <= '0;
`endif
          r_state <= ST_WAIT_ACK;
        end
        ST_WAIT_ACK: begin
          // ack_s takes priority over a timeout landing in the same cycle
          if (ack_s) begin
            r_done   <= w_gnt_onehot;
            r_ptr    <= w_ptr_adv;
            r_active <= 1'b0;
            r_state  <= ST_IDLE;
          end
`ifdef PULSEACK_EVT_ARB_TIMEOUT_EN
          else if (r_cnt == TMO_LAST) begin
            r_err    <= 1'b1;
            r_ptr    <= w_ptr_adv;
            r_active <= 1'b0;
            r_state  <= ST_IDLE;
          end else begin
            r_cnt <= r_cnt + TMO_CNT_W'(1);
          end
`endif
        end
        default: begin
          r_active <= 1'b0;
          r_state  <= ST_IDLE;
        end
      endcase
    end
  end

  assign done_s   = r_done;
  assign ovf_s    = r_ovf;
  assign gnt_id_s = r_gnt;
  assign active_s = r_active;
  assign event_s  = r_event;
`ifdef PULSEACK_EVT_ARB_TIMEOUT_EN
  assign err_s    = r_err;
`else
  assign err_s    = 1'b0;
`endif

endmodule
